// File: rtl/adder_rr_scheduler.sv
// Round-robin front end for one shared combinational adder: grants one requester
// at a time, holds its operands for ADD_LAT cycles and returns the tagged result.
module adder_rr_scheduler #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int ADD_LAT = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*WIDTH-1:0] req_a_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_b_i,
  input  logic [NUM_REQ-1:0]       req_cin_i,
  output logic [WIDTH-1:0]         add_a_o,
  output logic [WIDTH-1:0]         add_b_o,
  output logic                     add_cin_o,
  input  logic [WIDTH-1:0]         add_sum_i,
  input  logic                     add_cout_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [ID_W-1:0]          rsp_id_o,
  output logic [WIDTH-1:0]         rsp_sum_o,
  output logic                     rsp_cout_o,
  output logic                     rsp_of_o
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]   add_a_q, add_a_d;
  logic [WIDTH-1:0]   add_b_q, add_b_d;
  logic               add_cin_q, add_cin_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]   rsp_sum_q, rsp_sum_d;
  logic               rsp_cout_q, rsp_cout_d;
  logic               rsp_of_q, rsp_of_d;

  logic               grant_vld;
  logic [ID_W-1:0]    grant_idx;
  logic [ID_W-1:0]    cand;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!grant_vld && req_valid_i[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_cin_d   = add_cin_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_of_d    = rsp_of_q;
    req_ready_o = '0;
    unique case (state_q)
      IDLE: begin
        if (grant_vld) begin
          req_ready_o[grant_idx] = 1'b1;
          add_a_d   = req_a_i[int'(grant_idx)*WIDTH +: WIDTH];
          add_b_d   = req_b_i[int'(grant_idx)*WIDTH +: WIDTH];
          add_cin_d = req_cin_i[grant_idx];
          rsp_id_d  = grant_idx;
          cnt_d     = 4'(ADD_LAT - 1);
          state_d   = CALC;
        end
      end
      CALC: begin
        if (cnt_q == 4'd0) begin
          rsp_sum_d   = add_sum_i;
          rsp_cout_d  = add_cout_i;
          rsp_of_d    = (add_a_q[WIDTH-1] == add_b_q[WIDTH-1]) &&
                        (add_sum_i[WIDTH-1] != add_a_q[WIDTH-1]);
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        // Pointer moves past the requester just served, so it drops to lowest priority.
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          rr_ptr_d    = (rsp_id_q == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id_q + 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_cin_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_of_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_cin_q   <= add_cin_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_of_q    <= rsp_of_d;
    end
  end

  assign add_a_o     = add_a_q;
  assign add_b_o     = add_b_q;
  assign add_cin_o   = add_cin_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_sum_o   = rsp_sum_q;
  assign rsp_cout_o  = rsp_cout_q;
  assign rsp_of_o    = rsp_of_q;

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Scoreboard bench for adder_rr_scheduler: a behavioural adder hangs off add_*,
// requesters are driven from per-requester operation queues.
module tb_adder_rr_scheduler;
  localparam int WIDTH   = 32;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int ADD_LAT = 2;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
  } op_t;

  typedef struct {
    int               id;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } exp_t;

  logic                     clk;
  logic                     rstN;
  logic [NUM_REQ-1:0]       reqValid;
  logic [NUM_REQ-1:0]       reqReady;
  logic [NUM_REQ*WIDTH-1:0] reqA;
  logic [NUM_REQ*WIDTH-1:0] reqB;
  logic [NUM_REQ-1:0]       reqCin;
  logic [WIDTH-1:0]         addA;
  logic [WIDTH-1:0]         addB;
  logic                     addCin;
  logic [WIDTH-1:0]         addSum;
  logic                     addCout;
  logic                     rspValid;
  logic                     rspReady;
  logic [ID_W-1:0]          rspId;
  logic [WIDTH-1:0]         rspSum;
  logic                     rspCout;
  logic                     rspOf;
  logic [WIDTH:0]           addFull;

  op_t  pendQ[NUM_REQ][$];
  exp_t sb[$];
  int   grantLog[$];

  int   totalChecks = 0;
  int   badChecks   = 0;
  int   cyc         = 0;
  int   acceptCyc   = 0;
  int   hsCyc       = -100;
  int   lastGap     = 0;
  int   acceptIdx   = -1;
  int   modelPtr    = 0;
  logic prevRspValid = 1'b0;
  logic rspReadyDrv  = 1'b1;
  logic [WIDTH+3:0] lastRsp;

  // Behavioural stand-in for the shared adder.
  assign addFull = {1'b0, addA} + {1'b0, addB} + (WIDTH+1)'(addCin);
  assign addSum  = addFull[WIDTH-1:0];
  assign addCout = addFull[WIDTH];

  adder_rr_scheduler #(
    .WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W), .ADD_LAT(ADD_LAT)
  ) dut (
    .clk_i(clk), .rst_ni(rstN),
    .req_valid_i(reqValid), .req_ready_o(reqReady),
    .req_a_i(reqA), .req_b_i(reqB), .req_cin_i(reqCin),
    .add_a_o(addA), .add_b_o(addB), .add_cin_o(addCin),
    .add_sum_i(addSum), .add_cout_i(addCout),
    .rsp_valid_o(rspValid), .rsp_ready_i(rspReady),
    .rsp_id_o(rspId), .rsp_sum_o(rspSum), .rsp_cout_o(rspCout), .rsp_of_o(rspOf)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] want);
    totalChecks++;
    if (got !== want) begin
      badChecks++;
      $display("[TB] FAIL %s got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic int modelGrant(logic [NUM_REQ-1:0] v);
    for (int k = 0; k < NUM_REQ; k++) begin
      int i = (modelPtr + k) % NUM_REQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic int pendingCount();
    int n = 0;
    for (int i = 0; i < NUM_REQ; i++) n += pendQ[i].size();
    return n;
  endfunction

  task automatic queueOp(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
    op_t o;
    o.a = a; o.b = b; o.cin = cin;
    pendQ[id].push_back(o);
  endtask

  // Requesters present the head of their queue; rsp_ready follows the sequence's request.
  task automatic applyStimulus();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pendQ[i].size() > 0) begin
        reqValid[i]              = 1'b1;
        reqA[i*WIDTH +: WIDTH]   = pendQ[i][0].a;
        reqB[i*WIDTH +: WIDTH]   = pendQ[i][0].b;
        reqCin[i]                = pendQ[i][0].cin;
      end else begin
        reqValid[i] = 1'b0;
      end
    end
    rspReady = rspReadyDrv;
  endtask

  // Observes one cycle just before the rising edge that acts on it.
  task automatic monitorCycle();
    logic             sbWasEmpty;
    logic [NUM_REQ-1:0] expReady;
    int               g;
    exp_t             e;
    logic [WIDTH:0]   full;
    sbWasEmpty = (sb.size() == 0);
    acceptIdx  = -1;
    if (!sbWasEmpty) begin
      checkOutput("busyReady", reqReady, 0);
      checkOutput("addA", addA, sb[0].a);
      checkOutput("addB", addB, sb[0].b);
      checkOutput("addCin", addCin, sb[0].cin);
      if (rspValid) begin
        if (!prevRspValid) checkOutput("latency", cyc - acceptCyc, ADD_LAT + 1);
        checkOutput("rspId", rspId, sb[0].id);
        checkOutput("rspSum", rspSum, sb[0].sum);
        checkOutput("rspCout", rspCout, sb[0].cout);
        checkOutput("rspOf", rspOf, sb[0].ovf);
        if (rspReady) begin
          lastRsp  = {rspId, rspCout, rspOf, rspSum};
          modelPtr = (sb[0].id + 1) % NUM_REQ;
          hsCyc    = cyc;
          void'(sb.pop_front());
        end
      end
    end else begin
      checkOutput("spurious", rspValid, 0);
      g        = modelGrant(reqValid);
      expReady = (g >= 0) ? NUM_REQ'(1 << g) : '0;
      checkOutput("reqReady", reqReady, expReady);
      if (g >= 0 && (reqReady & reqValid) != 0) begin
        full    = {1'b0, pendQ[g][0].a} + {1'b0, pendQ[g][0].b} + (WIDTH+1)'(pendQ[g][0].cin);
        e.id    = g;
        e.a     = pendQ[g][0].a;
        e.b     = pendQ[g][0].b;
        e.cin   = pendQ[g][0].cin;
        e.sum   = full[WIDTH-1:0];
        e.cout  = full[WIDTH];
        e.ovf   = (e.a[WIDTH-1] == e.b[WIDTH-1]) && (e.sum[WIDTH-1] != e.a[WIDTH-1]);
        sb.push_back(e);
        grantLog.push_back(g);
        lastGap   = cyc - hsCyc;
        acceptCyc = cyc;
        acceptIdx = g;
      end
    end
    prevRspValid = rspValid;
  endtask

  task automatic tick();
    @(negedge clk);
    applyStimulus();
    #1;
    monitorCycle();
    @(posedge clk);
    if (acceptIdx >= 0) void'(pendQ[acceptIdx].pop_front());
    cyc++;
  endtask

  task automatic runUntilIdle(input int maxCyc);
    int n = 0;
    while ((sb.size() > 0 || pendingCount() > 0) && n < maxCyc) begin
      tick();
      n++;
    end
    checkOutput("drain", sb.size() + pendingCount(), 0);
  endtask

  task automatic checkZeroOutputs(input string tag);
    checkOutput(tag, {reqReady, addA, addB, addCin, rspValid, rspId, rspSum, rspCout, rspOf}, 0);
  endtask

  initial begin
    int expOrder[5] = '{0, 1, 2, 3, 0};
    int n;
    rstN     = 1'b0;
    reqValid = '0;
    reqA     = '0;
    reqB     = '0;
    reqCin   = '0;
    rspReady = 1'b1;

    // Reset held for three cycles with no requests, then ten idle cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 checkZeroOutputs("rstOut");
    end
    @(negedge clk) rstN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      #2 checkZeroOutputs("idleOut");
    end

    // Single add with signed overflow on requester 0.
    queueOp(0, 32'h7fffffff, 32'h7fffffff, 1'b0);
    runUntilIdle(20);
    checkOutput("vec0", lastRsp, {2'd0, 1'b0, 1'b1, 32'hfffffffe});

    // Negative plus negative on requester 2, then a small add with carry-in on requester 1.
    queueOp(2, 32'h8fffffff, 32'h8fffffff, 1'b0);
    runUntilIdle(20);
    checkOutput("vec2", lastRsp, {2'd2, 1'b1, 1'b1, 32'h1ffffffe});
    queueOp(1, 32'h000000af, 32'h000000af, 1'b1);
    runUntilIdle(20);
    checkOutput("vec1", lastRsp, {2'd1, 1'b0, 1'b0, 32'h0000015f});

    // Backpressure: hold the response for 20 cycles while requester 3 waits.
    rspReadyDrv = 1'b0;
    queueOp(2, 32'h12345678, 32'h9abcdef0, 1'b1);
    n = 0;
    while (!prevRspValid && n < 20) begin
      tick();
      n++;
    end
    checkOutput("bpReach", prevRspValid, 1);
    queueOp(3, 32'hdeadbeef, 32'h00000011, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    rspReadyDrv = 1'b1;
    runUntilIdle(20);
    checkOutput("bpGrantId", grantLog[grantLog.size()-1], 3);
    checkOutput("bpGrantGap", lastGap, 1);

    // All four requesters valid together, requester 0 with a second operation.
    grantLog.delete();
    for (int i = 0; i < NUM_REQ; i++) queueOp(i, 32'h11111111 * (i + 1), 32'hf0000000 + i, i[0]);
    queueOp(0, 32'h80000000, 32'h80000000, 1'b1);
    runUntilIdle(100);
    checkOutput("rrCount", grantLog.size(), 5);
    for (int i = 0; i < 5 && i < grantLog.size(); i++) checkOutput("rrOrder", grantLog[i], expOrder[i]);

    // Random traffic with occasional backpressure.
    for (int i = 0; i < 8; i++) queueOp($urandom_range(NUM_REQ - 1), $urandom, $urandom, 1'($urandom_range(1)));
    for (int i = 0; i < 40; i++) begin
      rspReadyDrv = 1'($urandom_range(1));
      tick();
    end
    rspReadyDrv = 1'b1;
    runUntilIdle(200);

    // Reset asserted mid-CALC aborts the operation.
    queueOp(1, 32'h00000001, 32'h00000002, 1'b0);
    n = 0;
    while (sb.size() == 0 && n < 20) begin
      tick();
      n++;
    end
    checkOutput("abortAccept", sb.size(), 1);
    tick();
    #2 rstN = 1'b0;
    #1;
    checkOutput("abortValid", rspValid, 0);
    checkZeroOutputs("abortOut");
    reqValid = 4'b0100;
    #1 checkOutput("abortIdle", reqReady, 4'b0100);
    reqValid = '0;
    sb.delete();
    for (int i = 0; i < NUM_REQ; i++) pendQ[i].delete();
    modelPtr     = 0;
    prevRspValid = 1'b0;
    @(negedge clk);
    @(negedge clk) rstN = 1'b1;
    for (int i = 0; i < 10; i++) tick();

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
